// File: rtl/msk_timing_pkg.sv
// msk_timing_pkg: shared constants, types and helpers for the MSK symbol-timing loop.
//   nom_inc(wacc, osf) : nominal phase increment, floor(2^wacc / osf)
//   vmax(wacc, osf)    : loop-filter output clamp, nom_inc / 4
//   sat_s(x, lim)      : symmetric signed saturation of x to +/-lim
//   acc_t / v_t        : default-width accumulator (unsigned) and filter (signed) words
package msk_timing_pkg;

  localparam int WACC_DEF = 32;

  typedef logic        [WACC_DEF-1:0] acc_t;
  typedef logic signed [WACC_DEF-1:0] v_t;

  function automatic logic [63:0] nom_inc(input int wacc, input int osf);
    return (64'd1 << wacc) / 64'(osf);
  endfunction

  function automatic logic [63:0] vmax(input int wacc, input int osf);
    return nom_inc(wacc, osf) / 64'd4;
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input logic signed [63:0] lim);
    if (x > lim) begin
      return lim;
    end else if (x < -lim) begin
      return -lim;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/timing_pi_filter.sv
// timing_pi_filter: proportional-integral loop filter for the symbol-timing loop.
//   clk, reset_n : sample clock, synchronous active-low reset
//   loop_en_i    : 1 = update on e_valid_i, 0 = clear integrator and output
//   e_in         : signed timing error, e_valid_i qualifies it
//   v            : registered, saturated filter output (signed, WACC bits)
module timing_pi_filter
  import msk_timing_pkg::*;
#(
  parameter int     WERR    = 18,
  parameter int     WACC    = 32,
  parameter int     KP_SH   = 4,
  parameter int     KI_SH   = 10,
  parameter longint INT_LIM = 64'sd16777216,
  parameter longint VMAX    = 64'sd53687091
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   loop_en_i,
  input  logic signed [WERR-1:0] e_in,
  input  logic                   e_valid_i,
  output logic signed [WACC-1:0] v
);

  // Two guard bits so neither sum can wrap before it is saturated.
  localparam int XW = WACC + 2;

  logic signed [WACC-1:0] integ_r;
  logic signed [WERR-1:0] e_kp_s;
  logic signed [WERR-1:0] e_ki_s;
  logic signed [XW-1:0]   p_s;
  logic signed [XW-1:0]   ki_s;
  logic signed [XW-1:0]   i_sum_s;
  logic signed [WACC-1:0] integ_n_s;
  logic signed [XW-1:0]   v_sum_s;
  logic signed [WACC-1:0] v_n_s;

  // Next integrator and output values from the current error.
  always_comb begin
    e_kp_s    = e_in >>> KP_SH;
    e_ki_s    = e_in >>> KI_SH;
    p_s       = {{(XW-WERR){e_kp_s[WERR-1]}}, e_kp_s};
    ki_s      = {{(XW-WERR){e_ki_s[WERR-1]}}, e_ki_s};
    i_sum_s   = {{2{integ_r[WACC-1]}}, integ_r} + ki_s;
    integ_n_s = WACC'(sat_s({{(64-XW){i_sum_s[XW-1]}}, i_sum_s}, INT_LIM));
    v_sum_s   = p_s + {{2{integ_n_s[WACC-1]}}, integ_n_s};
    v_n_s     = WACC'(sat_s({{(64-XW){v_sum_s[XW-1]}}, v_sum_s}, VMAX));
  end

  // Filter state: cleared when the loop is open, updated only on a valid error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      integ_r <= '0;
      v       <= '0;
    end else if (!loop_en_i) begin
      integ_r <= '0;
      v       <= '0;
    end else if (e_valid_i) begin
      integ_r <= integ_n_s;
      v       <= v_n_s;
    end else begin
      integ_r <= integ_r;
      v       <= v;
    end
  end

endmodule

// File: rtl/timing_loop_nco.sv
// timing_loop_nco: symbol-timing PI loop filter plus phase-accumulator NCO.
//   clk, reset_n : 200 MHz sample clock, synchronous active-low reset
//   loop_en_i    : 1 = loop closed, 0 = free-run at the nominal rate
//   e_in         : signed Gardner timing error, qualified by e_valid_i
//   sym_valid_o  : one-cycle symbol strobe (accumulator carry, registered)
//   mu_o         : fractional interval captured at each strobe
//   v_o          : current loop-filter output, for debug
module timing_loop_nco
  import msk_timing_pkg::*;
#(
  parameter int     OSF     = 20,
  parameter int     WERR    = 18,
  parameter int     WACC    = 32,
  parameter int     WMU     = 16,
  parameter int     KP_SH   = 4,
  parameter int     KI_SH   = 10,
  parameter longint INT_LIM = 64'sd16777216
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   loop_en_i,
  input  logic signed [WERR-1:0] e_in,
  input  logic                   e_valid_i,
  output logic                   sym_valid_o,
  output logic [WMU-1:0]         mu_o,
  output logic signed [WACC-1:0] v_o
);

  localparam logic [63:0] NOM_INC = nom_inc(WACC, OSF);
  localparam longint      VMAX    = longint'(vmax(WACC, OSF));
  localparam logic [63:0] MU_MAX  = (64'd1 << WMU) - 64'd1;

  logic [WACC-1:0] acc_r;
  logic [WACC-1:0] inc_s;
  logic [WACC:0]   acc_sum_s;
  logic [63:0]     mu_wide_s;
  logic [WMU-1:0]  mu_n_s;

  timing_pi_filter #(
    .WERR    (WERR),
    .WACC    (WACC),
    .KP_SH   (KP_SH),
    .KI_SH   (KI_SH),
    .INT_LIM (INT_LIM),
    .VMAX    (VMAX)
  ) u_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .loop_en_i (loop_en_i),
    .e_in      (e_in),
    .e_valid_i (e_valid_i),
    .v         (v_o)
  );

  // Accumulator step and mu candidate; v_o is the pre-update filter value,
  // and |v| <= NOM_INC/4 keeps the increment positive.
  always_comb begin
    inc_s     = NOM_INC[WACC-1:0] + v_o;
    acc_sum_s = {1'b0, acc_r} + {1'b0, inc_s};
    // Wrapped residue scaled by OSF, kept to the top WMU fraction bits.
    mu_wide_s = (64'(acc_sum_s[WACC-1:0]) * 64'(OSF)) >> (WACC - WMU);
    if (mu_wide_s > MU_MAX) begin
      mu_n_s = MU_MAX[WMU-1:0];
    end else begin
      mu_n_s = mu_wide_s[WMU-1:0];
    end
  end

  // Phase accumulator, symbol strobe and mu capture on carry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_r       <= '0;
      sym_valid_o <= 1'b0;
      mu_o        <= '0;
    end else begin
      acc_r       <= acc_sum_s[WACC-1:0];
      sym_valid_o <= acc_sum_s[WACC];
      if (acc_sum_s[WACC]) begin
        mu_o <= mu_n_s;
      end else begin
        mu_o <= mu_o;
      end
    end
  end

endmodule

// File: tb/tb_timing_loop_nco.sv
// tb_timing_loop_nco: directed self-checking bench for timing_loop_nco.
//   dut_a : default parameters, directed stimulus
//   dut_b : KI_SH=0, default INT_LIM, error fed back on every strobe
//   dut_c : KI_SH=0, INT_LIM=2^30, error fed back on every strobe
module tb_timing_loop_nco;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic               a_rst_n, a_loop_en, a_e_valid, a_sym;
  logic signed [17:0] a_e_in;
  logic [15:0]        a_mu;
  logic signed [31:0] a_v;

  logic               bc_rst_n, bc_loop_en;
  logic signed [17:0] bc_e_in;
  logic               b_e_valid, b_sym, c_e_valid, c_sym;
  logic [15:0]        b_mu, c_mu;
  logic signed [31:0] b_v, c_v;

  timing_loop_nco dut_a (
    .clk(clk), .reset_n(a_rst_n), .loop_en_i(a_loop_en), .e_in(a_e_in),
    .e_valid_i(a_e_valid), .sym_valid_o(a_sym), .mu_o(a_mu), .v_o(a_v)
  );

  timing_loop_nco #(.KI_SH(32'sd0)) dut_b (
    .clk(clk), .reset_n(bc_rst_n), .loop_en_i(bc_loop_en), .e_in(bc_e_in),
    .e_valid_i(b_e_valid), .sym_valid_o(b_sym), .mu_o(b_mu), .v_o(b_v)
  );

  timing_loop_nco #(.KI_SH(32'sd0), .INT_LIM(64'sd1073741824)) dut_c (
    .clk(clk), .reset_n(bc_rst_n), .loop_en_i(bc_loop_en), .e_in(bc_e_in),
    .e_valid_i(c_e_valid), .sym_valid_o(c_sym), .mu_o(c_mu), .v_o(c_v)
  );

  // Error returned in the strobe cycle, like the TED's combinational e_valid_o.
  always @(negedge clk) begin
    b_e_valid = b_sym;
    c_e_valid = c_sym;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Cycles until dut_a strobes, bounded.
  task automatic wait_sym(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!a_sym && n < budget);
    if (!a_sym) check_val("sym_timeout", 0, 1);
  endtask

  initial begin
    int n, gap, bad, min_gap, saw19;

    a_rst_n = 1'b0; a_loop_en = 1'b1; a_e_valid = 1'b0; a_e_in = 18'sd0;
    bc_rst_n = 1'b0; bc_loop_en = 1'b1; bc_e_in = 18'sd131071;
    repeat (3) step();
    check_val("rst_sym", a_sym, 0);
    check_val("rst_mu", a_mu, 0);
    check_val("rst_v", a_v, 0);

    // Free-run: first strobe 21 cycles after release, then every 20.
    a_rst_n = 1'b1; bc_rst_n = 1'b1;
    wait_sym(40, n);
    check_val("first_sym_cycle", n, 21);
    check_val("first_mu", a_mu, 65535);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_sym(40, n);
      if (n != 20) bad++;
    end
    check_val("period20_bad", bad, 0);

    // Constant +4096 error on every strobe.
    min_gap = 1000; saw19 = 0;
    for (int k = 0; k < 50; k++) begin
      a_e_in = 18'sd4096; a_e_valid = 1'b1;
      step();
      a_e_valid = 1'b0;
      if (k < 3) check_val("v_track", a_v, 260 + 4 * k);
      wait_sym(40, n);
      gap = n + 1;
      if (gap < min_gap) min_gap = gap;
      if (gap == 19) saw19 = 1;
    end
    check_val("v_after50", a_v, 456);
    check_val("saw_period19", saw19, 1);
    check_val("min_gap", min_gap, 19);

    // Negative error in the strobe cycle.
    a_e_in = -18'sd65536; a_e_valid = 1'b1;
    step();
    a_e_valid = 1'b0;
    check_val("v_neg", a_v, -3960);
    check_val("strobe_one_cycle", a_sym, 0);
    wait_sym(40, n);
    gap = n + 1;
    check_val("neg_gap_20_21", (gap >= 20 && gap <= 21) ? 1 : 0, 1);

    // Open the loop with v nonzero.
    repeat (5) step();
    a_loop_en = 1'b0;
    step();
    check_val("v_open", a_v, 0);
    a_e_in = 18'sd4096; a_e_valid = 1'b1;
    step();
    a_e_valid = 1'b0;
    step();
    check_val("v_open_ignores_err", a_v, 0);
    wait_sym(40, n);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      wait_sym(40, n);
      if (n != 20) bad++;
    end
    check_val("open_period20_bad", bad, 0);

    // Re-close, then a one-cycle reset mid-symbol.
    a_loop_en = 1'b1; a_e_in = 18'sd4096; a_e_valid = 1'b1;
    step();
    a_e_valid = 1'b0;
    check_val("v_reclose", a_v, 260);
    repeat (6) step();
    a_rst_n = 1'b0;
    step();
    check_val("midrst_sym", a_sym, 0);
    check_val("midrst_mu", a_mu, 0);
    check_val("midrst_v", a_v, 0);
    a_rst_n = 1'b1;
    wait_sym(40, n);
    check_val("midrst_first_sym", n, 21);
    check_val("midrst_first_mu", a_mu, 65535);

    // Saturation instances.
    check_val("b_integ_clamp_v", b_v, 16785407);
    check_val("c_vmax_clamp_v", c_v, 53687091);
    n = 0;
    do begin step(); n++; end while (!c_sym && n < 40);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin step(); n++; end while (!c_sym && n < 40);
      if (n != 16) bad++;
    end
    check_val("c_period16_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
